fu_writeback_arbiter: RTL

//  Shares the single register-file write port among the scalar functional units
//  (arith, mult, div, lsu) that decode steers via sfu_type. Each unit gets a 1-entry

---
 rtl/fu_writeback_arbiter_if.sv | 39 +++
 rtl/fu_writeback_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fu_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fu_writeback_arbiter_if
//  Description : Bundle of functional-unit result handshakes, register-file
//                write port and issue-side hazard query for the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fu_writeback_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
);
   logic                       flush;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*RADDR_W-1:0] req_rd;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       wb_en;
   logic [RADDR_W-1:0]         wb_rd;
   logic [DATA_W-1:0]          wb_data;
   logic [NUM_REQ-1:0]         wb_src;
   logic [RADDR_W-1:0]         reg_rs1;
   logic [RADDR_W-1:0]         reg_rs2;
   logic                       hazard;
   logic                       busy;

   // Pipeline / unit side: drives results and decoded sources
   modport master (
      output flush, req_valid, req_rd, req_data, reg_rs1, reg_rs2,
      input  req_ready, wb_en, wb_rd, wb_data, wb_src, hazard, busy
   );

   // Arbiter side
   modport slave (
      input  flush, req_valid, req_rd, req_data, reg_rs1, reg_rs2,
      output req_ready, wb_en, wb_rd, wb_data, wb_src, hazard, busy
   );
endinterface
`default_nettype wire

// File: rtl/fu_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fu_writeback_arbiter
//  Description : One holding buffer per scalar functional unit, drained one
//                per cycle to the single RF write port by a round-robin
//                arbiter. Flags RAW hazards against pending buffered results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_writeback_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   fu_writeback_arbiter_if.slave bus
);

   localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] r_hold_v;
   logic [RADDR_W-1:0] r_hold_rd   [NUM_REQ];
   logic [DATA_W-1:0]  r_hold_data [NUM_REQ];
   logic [c_PTR_W-1:0] r_rr_ptr;

   logic               r_wb_en;
   logic [RADDR_W-1:0] r_wb_rd;
   logic [DATA_W-1:0]  r_wb_data;
   logic [NUM_REQ-1:0] r_wb_src;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_grant_any;
   logic [c_PTR_W-1:0] w_grant_idx;
   logic [c_PTR_W-1:0] w_scan_idx;
   logic [NUM_REQ-1:0] w_ready;
   logic [NUM_REQ-1:0] w_accept;
   logic               w_hazard;

   // Modulo-NUM_REQ increment of a requester index
   function automatic logic [c_PTR_W-1:0] f_wrap_add(input logic [c_PTR_W-1:0] base,
                                                     input int offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return c_PTR_W'(sum);
   endfunction

   // Rotating-priority scan: first full buffer at or after the rr pointer
   always_comb begin
      w_grant     = '0;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan_idx = f_wrap_add(r_rr_ptr, k);
         if (!w_grant_any && r_hold_v[w_scan_idx]) begin
            w_grant_any = 1'b1;
            w_grant_idx = w_scan_idx;
         end
      end
      if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
   end

   // A buffer can take a new result when empty or being drained this cycle
   always_comb begin
      w_ready  = {NUM_REQ{~bus.flush}} & (~r_hold_v | w_grant);
      w_accept = bus.req_valid & w_ready;
   end

   // RAW check of decoded sources against buffered destinations (x0 never hazards)
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_hold_v[i]) begin
            if ((bus.reg_rs1 != '0) && (bus.reg_rs1 == r_hold_rd[i])) w_hazard = 1'b1;
            if ((bus.reg_rs2 != '0) && (bus.reg_rs2 == r_hold_rd[i])) w_hazard = 1'b1;
         end
      end
   end

   // Buffer occupancy, rr pointer and registered RF write stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_v  <= '0;
         r_rr_ptr  <= '0;
         r_wb_en   <= 1'b0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_wb_src  <= '0;
      end else if (bus.flush) begin
         // Drop everything pending; pointer and last address/data are kept
         r_hold_v <= '0;
         r_wb_en  <= 1'b0;
         r_wb_src <= '0;
      end else begin
         r_wb_en  <= w_grant_any;
         r_wb_src <= w_grant;
         if (w_grant_any) begin
            r_wb_rd   <= r_hold_rd[w_grant_idx];
            r_wb_data <= r_hold_data[w_grant_idx];
            r_rr_ptr  <= f_wrap_add(w_grant_idx, 1);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            // Results for x0 are acknowledged but never occupy the buffer
            if (w_accept[i] && (bus.req_rd[i*RADDR_W +: RADDR_W] != '0))
               r_hold_v[i] <= 1'b1;
            else if (w_grant[i])
               r_hold_v[i] <= 1'b0;
         end
      end
   end

   // Payload capture; validity is tracked separately so no reset is needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept[i]) begin
            r_hold_rd[i]   <= bus.req_rd[i*RADDR_W +: RADDR_W];
            r_hold_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_data   = r_wb_data;
   assign bus.wb_src    = r_wb_src;
   assign bus.hazard    = w_hazard;
   assign bus.busy      = |r_hold_v;

endmodule
`default_nettype wire
